// File: rtl/axi_lite_master_pkg.sv
// Shared AXI-Lite constants for the axi_lite_master slice: response codes,
// bus widths and the fixed full-word write strobe.
package axi_lite_master_pkg;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
    localparam axi_resp_t AXI_RESP_EXOKAY = 2'b01;
    localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;
    localparam axi_resp_t AXI_RESP_DECERR = 2'b11;

    localparam logic [AXI_STRB_W-1:0] AXI_WSTRB_FULL = '1;

endpackage

// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus bundle; signal prefixes are from the master's point of view
// so the master modport keeps the i_/o_ direction naming.
interface axi_lite_master_if
    import axi_lite_master_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) ();

    logic                  o_awvalid;
    logic [ADDR_WIDTH-1:0] o_awaddr;
    logic                  i_awready;

    logic                  o_wvalid;
    logic [AXI_DATA_W-1:0] o_wdata;
    logic [AXI_STRB_W-1:0] o_wstrb;
    logic                  i_wready;

    logic                  i_bvalid;
    logic                  o_bready;
    axi_resp_t             i_bresp;

    logic                  o_arvalid;
    logic [ADDR_WIDTH-1:0] o_araddr;
    logic                  i_arready;

    logic                  i_rvalid;
    logic                  o_rready;
    axi_resp_t             i_rresp;
    logic [AXI_DATA_W-1:0] i_rdata;

    modport master (
        output o_awvalid, o_awaddr, o_wvalid, o_wdata, o_wstrb, o_bready,
               o_arvalid, o_araddr, o_rready,
        input  i_awready, i_wready, i_bvalid, i_bresp, i_arready,
               i_rvalid, i_rresp, i_rdata
    );

    modport slave (
        input  o_awvalid, o_awaddr, o_wvalid, o_wdata, o_wstrb, o_bready,
               o_arvalid, o_araddr, o_rready,
        output i_awready, i_wready, i_bvalid, i_bresp, i_arready,
               i_rvalid, i_rresp, i_rdata
    );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master driven by a one-shot command port.
// Define AXI_LITE_MASTER_TIMEOUT_EN to build the hung-slave watchdog.
module axi_lite_master
    import axi_lite_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_lite_master_if.master     bus,
    input  logic                  i_cmd_en,
    input  logic                  i_cmd_wr,
    input  logic [ADDR_WIDTH-1:0] i_cmd_address,
    input  logic [AXI_DATA_W-1:0] i_cmd_data,
    output logic                  o_cmd_busy,
    output logic                  o_cmd_done,
    output logic [AXI_DATA_W-1:0] o_cmd_data,
    output axi_resp_t             o_cmd_resp,
    output logic                  o_cmd_timeout
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE_REQ,
        WRITE_RESP,
        READ_REQ,
        READ_RESP
    } state_t;

    state_t r_state;
    logic   w_awAccepted;
    logic   w_wAccepted;
    logic   w_timeoutHit;

    // A channel whose valid is already low was accepted on an earlier edge.
    assign w_awAccepted = !bus.o_awvalid || bus.i_awready;
    assign w_wAccepted  = !bus.o_wvalid  || bus.i_wready;

    assign bus.o_wstrb = AXI_WSTRB_FULL;

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] r_timer;

    always_ff @(posedge clk) begin
        if (rst || r_state == IDLE) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TIMER_W'(1);
        end
    end

    assign w_timeoutHit = (r_state != IDLE) && (r_timer == TIMER_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeoutHit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            bus.o_awvalid <= 1'b0;
            bus.o_awaddr  <= '0;
            bus.o_wvalid  <= 1'b0;
            bus.o_wdata   <= '0;
            bus.o_bready  <= 1'b0;
            bus.o_arvalid <= 1'b0;
            bus.o_araddr  <= '0;
            bus.o_rready  <= 1'b0;
            o_cmd_busy    <= 1'b0;
            o_cmd_done    <= 1'b0;
            o_cmd_data    <= '0;
            o_cmd_resp    <= AXI_RESP_OKAY;
            o_cmd_timeout <= 1'b0;
        end else begin
            o_cmd_done    <= 1'b0;
            o_cmd_timeout <= 1'b0;
            if (w_timeoutHit) begin
                // Abandon the hung transaction even mid-handshake.
                bus.o_awvalid <= 1'b0;
                bus.o_wvalid  <= 1'b0;
                bus.o_bready  <= 1'b0;
                bus.o_arvalid <= 1'b0;
                bus.o_rready  <= 1'b0;
                o_cmd_resp    <= AXI_RESP_SLVERR;
                o_cmd_done    <= 1'b1;
                o_cmd_timeout <= 1'b1;
                o_cmd_busy    <= 1'b0;
                r_state       <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_cmd_en) begin
                            o_cmd_busy <= 1'b1;
                            if (i_cmd_wr) begin
                                bus.o_awaddr  <= i_cmd_address;
                                bus.o_wdata   <= i_cmd_data;
                                bus.o_awvalid <= 1'b1;
                                bus.o_wvalid  <= 1'b1;
                                r_state       <= WRITE_REQ;
                            end else begin
                                bus.o_araddr  <= i_cmd_address;
                                bus.o_arvalid <= 1'b1;
                                r_state       <= READ_REQ;
                            end
                        end
                    end
                    WRITE_REQ: begin
                        if (bus.i_awready) begin
                            bus.o_awvalid <= 1'b0;
                        end
                        if (bus.i_wready) begin
                            bus.o_wvalid <= 1'b0;
                        end
                        if (w_awAccepted && w_wAccepted) begin
                            bus.o_bready <= 1'b1;
                            r_state      <= WRITE_RESP;
                        end
                    end
                    WRITE_RESP: begin
                        if (bus.i_bvalid) begin
                            o_cmd_resp   <= bus.i_bresp;
                            o_cmd_done   <= 1'b1;
                            o_cmd_busy   <= 1'b0;
                            bus.o_bready <= 1'b0;
                            r_state      <= IDLE;
                        end
                    end
                    READ_REQ: begin
                        if (bus.i_arready) begin
                            bus.o_arvalid <= 1'b0;
                            bus.o_rready  <= 1'b1;
                            r_state       <= READ_RESP;
                        end
                    end
                    READ_RESP: begin
                        if (bus.i_rvalid) begin
                            o_cmd_data   <= bus.i_rdata;
                            o_cmd_resp   <= bus.i_rresp;
                            o_cmd_done   <= 1'b1;
                            o_cmd_busy   <= 1'b0;
                            bus.o_rready <= 1'b0;
                            r_state      <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a delay-programmable slave plus a cycle-level
// latency model derived from the handshake rules.
module tb_axi_lite_master;
    import axi_lite_master_pkg::*;

    localparam int AW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmdEn;
    logic            cmdWr;
    logic [AW-1:0]   cmdAddr;
    logic [31:0]     cmdData;
    logic            cmdBusy;
    logic            cmdDone;
    logic [31:0]     cmdRdata;
    axi_resp_t       cmdResp;
    logic            cmdTimeout;

    int vectors = 0;
    int miscompares = 0;
    int edgeCnt = 0;

    int        awDelay, wDelay, bDelay, arDelay, rDelay;
    axi_resp_t slvBresp, slvRresp;
    logic [31:0] slvRdata;

    logic [7:0]    awHs, wHs, bHs, arHs, rHs;
    logic [AW-1:0] awaddrSeen, araddrSeen;
    logic [31:0]   wdataSeen;
    logic [3:0]    wstrbSeen;

    logic [31:0] modelData;
    axi_resp_t   modelResp;

    always #5 clk = ~clk;

    always @(posedge clk) edgeCnt++;

    axi_lite_master_if #(.ADDR_WIDTH(AW)) bus ();

    axi_lite_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .i_cmd_en(cmdEn),
        .i_cmd_wr(cmdWr),
        .i_cmd_address(cmdAddr),
        .i_cmd_data(cmdData),
        .o_cmd_busy(cmdBusy),
        .o_cmd_done(cmdDone),
        .o_cmd_data(cmdRdata),
        .o_cmd_resp(cmdResp),
        .o_cmd_timeout(cmdTimeout)
    );

    // Slave: 1 time unit after each edge, account for the handshakes that edge
    // completed, then choose this cycle's ready/valid from the programmed delays.
    initial begin
        int awWait, wWait, bWait, arWait, rWait;
        logic awGot, wGot, arGot;
        logic lastAwV, lastAwR, lastWV, lastWR, lastBV, lastBR;
        logic lastArV, lastArR, lastRV, lastRR;
        logic [AW-1:0] lastAwAddr, lastArAddr;
        logic [31:0] lastWdata;
        logic [3:0] lastWstrb;
        {bus.i_awready, bus.i_wready, bus.i_bvalid, bus.i_arready, bus.i_rvalid} = '0;
        bus.i_bresp = '0;
        bus.i_rresp = '0;
        bus.i_rdata = '0;
        awWait = 0; wWait = 0; bWait = 0; arWait = 0; rWait = 0;
        {awGot, wGot, arGot} = '0;
        {lastAwV, lastAwR, lastWV, lastWR, lastBV, lastBR, lastArV, lastArR, lastRV, lastRR} = '0;
        lastAwAddr = '0; lastArAddr = '0; lastWdata = '0; lastWstrb = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                {bus.i_awready, bus.i_wready, bus.i_bvalid, bus.i_arready, bus.i_rvalid} = '0;
                awWait = 0; wWait = 0; bWait = 0; arWait = 0; rWait = 0;
                {awGot, wGot, arGot} = '0;
            end else begin
                if (lastAwV && lastAwR) begin awHs++; awGot = 1'b1; awaddrSeen = lastAwAddr; end
                if (lastWV && lastWR) begin wHs++; wGot = 1'b1; wdataSeen = lastWdata; wstrbSeen = lastWstrb; end
                if (lastArV && lastArR) begin arHs++; arGot = 1'b1; araddrSeen = lastArAddr; end
                if (lastBV && lastBR) begin bHs++; awGot = 1'b0; wGot = 1'b0; bus.i_bvalid = 1'b0; bWait = 0; end
                if (lastRV && lastRR) begin rHs++; arGot = 1'b0; bus.i_rvalid = 1'b0; rWait = 0; end

                if (bus.o_awvalid) begin bus.i_awready = (awWait >= awDelay); awWait++; end
                else begin bus.i_awready = 1'b0; awWait = 0; end
                if (bus.o_wvalid) begin bus.i_wready = (wWait >= wDelay); wWait++; end
                else begin bus.i_wready = 1'b0; wWait = 0; end
                if (bus.o_arvalid) begin bus.i_arready = (arWait >= arDelay); arWait++; end
                else begin bus.i_arready = 1'b0; arWait = 0; end

                if (awGot && wGot && !bus.i_bvalid) begin
                    if (bWait >= bDelay) begin bus.i_bvalid = 1'b1; bus.i_bresp = slvBresp; end
                    else bWait++;
                end
                if (arGot && !bus.i_rvalid) begin
                    if (rWait >= rDelay) begin
                        bus.i_rvalid = 1'b1; bus.i_rresp = slvRresp; bus.i_rdata = slvRdata;
                    end else rWait++;
                end
            end
            lastAwV = bus.o_awvalid; lastAwR = bus.i_awready; lastAwAddr = bus.o_awaddr;
            lastWV = bus.o_wvalid; lastWR = bus.i_wready; lastWdata = bus.o_wdata; lastWstrb = bus.o_wstrb;
            lastBV = bus.i_bvalid; lastBR = bus.o_bready;
            lastArV = bus.o_arvalid; lastArR = bus.i_arready; lastArAddr = bus.o_araddr;
            lastRV = bus.i_rvalid; lastRR = bus.o_rready;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic setSlave(input int aw, input int w, input int b, input int ar, input int r,
                            input axi_resp_t bresp, input axi_resp_t rresp, input logic [31:0] rdata);
        awDelay = aw; wDelay = w; bDelay = b; arDelay = ar; rDelay = r;
        slvBresp = bresp; slvRresp = rresp; slvRdata = rdata;
    endtask

    function automatic logic [7:0] statusVec();
        return {bus.o_awvalid, bus.o_wvalid, bus.o_bready, bus.o_arvalid, bus.o_rready,
                cmdBusy, cmdDone, cmdTimeout};
    endfunction

    // Issue one command at the current negedge and check every cycle up to the
    // predicted done cycle; optionally pulse cmdEn while busy.
    task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [31:0] data,
                                 input bit spam, input bit chain);
        int n, dn, slow;
        logic [7:0] expVec;
        awHs = 0; wHs = 0; bHs = 0; arHs = 0; rHs = 0;
        cmdEn = 1'b1; cmdWr = wr; cmdAddr = addr; cmdData = data;
        n = edgeCnt + 1;
        slow = (awDelay > wDelay) ? awDelay : wDelay;
        dn = wr ? (n + 2 + slow + bDelay) : (n + 2 + arDelay + rDelay);
        for (int e = n; e <= dn; e++) begin
            @(negedge clk);
            if (spam && e < dn) begin
                cmdEn = 1'b1; cmdWr = 1'($urandom); cmdAddr = AW'($urandom); cmdData = $urandom;
            end else begin
                cmdEn = 1'b0;
            end
            expVec = {wr && (e <= n + awDelay), wr && (e <= n + wDelay),
                      wr && (e >= n + 1 + slow) && (e < dn), !wr && (e <= n + arDelay),
                      !wr && (e >= n + 1 + arDelay) && (e < dn), e < dn, e == dn, 1'b0};
            checkOutput("cycle status", 32'(statusVec()), 32'(expVec));
            if (e == n && wr) begin
                checkOutput("awaddr", 32'(bus.o_awaddr), 32'(addr));
                checkOutput("wdata", bus.o_wdata, data);
                checkOutput("wstrb", 32'(bus.o_wstrb), 32'hF);
            end
            if (e == n && !wr) checkOutput("araddr", 32'(bus.o_araddr), 32'(addr));
        end
        if (wr) begin
            modelResp = slvBresp;
        end else begin
            modelData = slvRdata;
            modelResp = slvRresp;
        end
        checkOutput("cmd resp", 32'(cmdResp), 32'(modelResp));
        checkOutput("cmd data", cmdRdata, modelData);
        checkOutput("handshakes", {awHs, wHs, bHs, 8'(arHs + rHs)},
                    wr ? 32'h01010100 : 32'h00000002);
        if (wr) checkOutput("slave saw wdata", wdataSeen, data);
        else checkOutput("slave saw araddr", 32'(araddrSeen), 32'(addr));
        if (!chain) begin
            @(negedge clk);
            checkOutput("idle after done", 32'({cmdBusy, cmdDone}), 32'h0);
        end
    endtask

    initial begin
        int n;
        bit rwr, rspam, rchain;
        rst = 1'b1;
        cmdEn = 1'b0; cmdWr = 1'b0; cmdAddr = '0; cmdData = '0;
        awHs = 0; wHs = 0; bHs = 0; arHs = 0; rHs = 0;
        awaddrSeen = '0; araddrSeen = '0; wdataSeen = '0; wstrbSeen = '0;
        modelData = '0; modelResp = AXI_RESP_OKAY;
        setSlave(0, 0, 0, 0, 0, AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0);

        repeat (3) @(negedge clk);
        checkOutput("reset status", 32'(statusVec()), 32'h0);
        checkOutput("reset awaddr", 32'(bus.o_awaddr), 32'h0);
        checkOutput("reset araddr", 32'(bus.o_araddr), 32'h0);
        checkOutput("reset wdata", bus.o_wdata, 32'h0);
        checkOutput("reset cmd data", cmdRdata, 32'h0);
        checkOutput("reset cmd resp", 32'(cmdResp), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] zero-wait write");
        applyStimulus(1'b1, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b0);
        checkOutput("wstrb seen", 32'(wstrbSeen), 32'hF);

        $display("[TB] AW first, W three cycles later");
        setSlave(0, 3, 1, 0, 0, AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0);
        applyStimulus(1'b1, 16'h0020, 32'hCAFEF00D, 1'b0, 1'b0);
        checkOutput("awaddr seen", 32'(awaddrSeen), 32'h0020);

        $display("[TB] delayed DECERR read");
        setSlave(0, 0, 0, 0, 5, AXI_RESP_OKAY, AXI_RESP_DECERR, 32'h12345678);
        applyStimulus(1'b0, 16'h0004, 32'h0, 1'b0, 1'b0);

        $display("[TB] back-to-back write then read with ignored strobes");
        setSlave(1, 0, 0, 0, 0, AXI_RESP_SLVERR, AXI_RESP_OKAY, 32'hA5A55A5A);
        applyStimulus(1'b1, 16'h0100, 32'h01020304, 1'b1, 1'b1);
        applyStimulus(1'b0, 16'h0104, 32'h0, 1'b1, 1'b0);

        $display("[TB] reset during WRITE_RESP");
        setSlave(0, 0, 5, 0, 0, AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0);
        cmdEn = 1'b1; cmdWr = 1'b1; cmdAddr = 16'h0200; cmdData = 32'h11112222;
        @(negedge clk);
        cmdEn = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("bready before reset", 32'(bus.o_bready), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelData = '0; modelResp = AXI_RESP_OKAY;
        checkOutput("status after reset", 32'(statusVec()), 32'h0);
        checkOutput("awaddr after reset", 32'(bus.o_awaddr), 32'h0);
        checkOutput("wdata after reset", bus.o_wdata, 32'h0);
        checkOutput("cmd data after reset", cmdRdata, 32'h0);
        @(negedge clk);
        checkOutput("no done after reset", 32'(cmdDone), 32'h0);
        setSlave(0, 0, 0, 0, 0, AXI_RESP_EXOKAY, AXI_RESP_OKAY, 32'h0);
        applyStimulus(1'b1, 16'h0204, 32'h33334444, 1'b0, 1'b0);

`ifdef AXI_LITE_MASTER_TIMEOUT_EN
        $display("[TB] watchdog on a slave that never accepts AR");
        setSlave(0, 0, 0, 100000, 0, AXI_RESP_OKAY, AXI_RESP_OKAY, 32'h0);
        cmdEn = 1'b1; cmdWr = 1'b0; cmdAddr = 16'h0300;
        n = edgeCnt + 1;
        for (int e = n; e <= n + 16; e++) begin
            @(negedge clk);
            cmdEn = 1'b0;
            checkOutput("watchdog status", 32'(statusVec()),
                        32'({1'b0, 1'b0, 1'b0, e <= n + 15, 1'b0, e < n + 16, e == n + 16, e == n + 16}));
        end
        modelResp = AXI_RESP_SLVERR;
        checkOutput("watchdog resp", 32'(cmdResp), 32'(modelResp));
        @(negedge clk);
        checkOutput("watchdog done cleared", 32'({cmdDone, cmdTimeout}), 32'h0);
`else
        n = 0;
`endif

        $display("[TB] randomized commands");
        for (int i = 0; i < 12; i++) begin
            setSlave($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3),
                     axi_resp_t'($urandom_range(0, 3)), axi_resp_t'($urandom_range(0, 3)), $urandom);
            rwr = ($urandom_range(0, 1) == 1);
            rspam = ($urandom_range(0, 1) == 1);
            rchain = (i != 11) && ($urandom_range(0, 1) == 1);
            applyStimulus(rwr, AW'($urandom), $urandom, rspam, rchain);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
